clk_ctrl_sequencer: RTL and testbench

- Command-driven control stage sitting directly upstream of the controller's clock divider (ClkDivider).
- Decodes 32-bit commands from the host command path (valid/ready) into the divider's control inputs: divider, option, out_enable, pulse, write_pulse.
- Keeps a cycle-exact shadow of the divider's pulse counter. This lets it report remaining pulses and block on a "pulse and wait" command until the DUT has received every requested clock.

---
 rtl/clk_ctrl_sequencer_pkg.sv | 31 +++
 rtl/clk_ctrl_sequencer_if.sv | 20 ++
 rtl/clk_ctrl_sequencer_pulse_shadow.sv | 38 +++
 rtl/clk_ctrl_sequencer.sv | 156 +++++++++++++++
 tb/tb_clk_ctrl_sequencer.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/clk_ctrl_sequencer_pkg.sv
// Shared types and command-word field layout for the clock-divider control sequencer.
// Opcode values match the host command protocol; arguments occupy the low 24 bits.
package clk_ctrl_pkg;

    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 24;
    localparam int ARG_WIDTH  = 24;

    typedef enum logic [7:0] {
        OP_SET_DIV    = 8'h01,
        OP_SET_MODE   = 8'h02,
        OP_ENABLE     = 8'h03,
        OP_PULSE      = 8'h04,
        OP_PULSE_WAIT = 8'h05,
        OP_STOP       = 8'h06,
        OP_CLR_ERR    = 8'h07
    } opcode_t;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    // Divide ratios below 2 cannot be produced by the downstream divider.
    localparam logic [ARG_WIDTH-1:0] MIN_DIVIDER = 24'd2;

    function automatic logic [ARG_WIDTH-1:0] clamp_divider(input logic [ARG_WIDTH-1:0] arg);
        return (arg < MIN_DIVIDER) ? MIN_DIVIDER : arg;
    endfunction

endpackage

// File: rtl/clk_ctrl_sequencer_if.sv
// Host command path into the sequencer: a 32-bit command word with valid/ready handshake.
interface clk_ctrl_sequencer_if;

    logic        cmd_valid;
    logic [31:0] cmd_data;
    logic        cmd_ready;

    modport master (
        output cmd_valid,
        output cmd_data,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_data,
        output cmd_ready
    );

endinterface

// File: rtl/clk_ctrl_sequencer_pulse_shadow.sv
// Cycle-exact copy of the divider stage's pulse counter, driven by the same control
// signals the divider sees, so the sequencer knows how many clocks are still owed.
module pulse_shadow #(
    parameter int PULSE_CONTROL_BITS = 32
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          out_enable,
    input  logic                          write_pulse,
    input  logic [PULSE_CONTROL_BITS-1:0] pulse,
    output logic [PULSE_CONTROL_BITS-1:0] count
);

    logic [PULSE_CONTROL_BITS-1:0] count_q;
    logic [PULSE_CONTROL_BITS-1:0] count_d;

    // A load in the same cycle as a countdown step wins, exactly as downstream.
    always_comb begin
        count_d = count_q;
        if (out_enable && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
        if (write_pulse) begin
            count_d = pulse;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/clk_ctrl_sequencer.sv
// Decodes host commands into the clock divider's control inputs and, for PULSE_WAIT,
// stalls the command path until the shadow counter shows every requested clock delivered.
module clk_ctrl_sequencer
    import clk_ctrl_pkg::*;
#(
    parameter int COUNTER_BITS       = 32,
    parameter int PULSE_CONTROL_BITS = 32,
    parameter int DEFAULT_DIVIDER    = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    clk_ctrl_sequencer_if.slave           cmd,
    output logic [COUNTER_BITS-1:0]       divider,
    output logic                          option,
    output logic                          out_enable,
    output logic [PULSE_CONTROL_BITS-1:0] pulse,
    output logic                          write_pulse,
    output logic [PULSE_CONTROL_BITS-1:0] pulses_left,
    output logic                          busy,
    output logic                          done,
    output logic                          err
);

    state_t                        state_q, state_d;
    logic [COUNTER_BITS-1:0]       divider_q, divider_d;
    logic                          option_q, option_d;
    logic                          out_enable_q, out_enable_d;
    logic [PULSE_CONTROL_BITS-1:0] pulse_q, pulse_d;
    logic                          write_pulse_q, write_pulse_d;
    logic                          done_q, done_d;
    logic                          err_q, err_d;

    logic [PULSE_CONTROL_BITS-1:0] shadow_count;
    logic                          cmd_accept;
    logic [7:0]                    cmd_opcode;
    logic [ARG_WIDTH-1:0]          cmd_arg;
    logic                          shadow_drained;

    assign cmd_opcode = cmd.cmd_data[OPCODE_MSB:OPCODE_LSB];
    assign cmd_arg    = cmd.cmd_data[ARG_WIDTH-1:0];
    assign cmd_accept = cmd.cmd_valid && (state_q == IDLE);

    // While the load strobe is still out, the shadow holds the stale count, so it
    // cannot be trusted as "drained" until the strobe has gone.
    assign shadow_drained = !write_pulse_q && (shadow_count == '0);

    always_comb begin
        state_d       = state_q;
        divider_d     = divider_q;
        option_d      = option_q;
        out_enable_d  = out_enable_q;
        pulse_d       = pulse_q;
        write_pulse_d = 1'b0;
        done_d        = 1'b0;
        err_d         = err_q;

        case (state_q)
            IDLE: begin
                if (cmd_accept) begin
                    case (cmd_opcode)
                        OP_SET_DIV: begin
                            divider_d = COUNTER_BITS'(clamp_divider(cmd_arg));
                        end
                        OP_SET_MODE: begin
                            option_d = cmd_arg[0];
                        end
                        OP_ENABLE: begin
                            out_enable_d = cmd_arg[0];
                        end
                        OP_PULSE: begin
                            pulse_d       = PULSE_CONTROL_BITS'(cmd_arg);
                            write_pulse_d = 1'b1;
                        end
                        OP_PULSE_WAIT: begin
                            pulse_d       = PULSE_CONTROL_BITS'(cmd_arg);
                            write_pulse_d = 1'b1;
                            // With the divider disabled the count never drains, so refuse to wait.
                            if (!out_enable_q) begin
                                err_d = 1'b1;
                            end else if (cmd_arg == '0) begin
                                done_d = 1'b1;
                            end else begin
                                state_d = WAIT;
                            end
                        end
                        OP_STOP: begin
                            out_enable_d  = 1'b0;
                            pulse_d       = '0;
                            write_pulse_d = 1'b1;
                        end
                        OP_CLR_ERR: begin
                            err_d = 1'b0;
                        end
                        default: begin
                            err_d = 1'b1;
                        end
                    endcase
                end
            end
            WAIT: begin
                if (shadow_drained) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            divider_q     <= COUNTER_BITS'(DEFAULT_DIVIDER);
            option_q      <= 1'b0;
            out_enable_q  <= 1'b0;
            pulse_q       <= '0;
            write_pulse_q <= 1'b0;
            done_q        <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            divider_q     <= divider_d;
            option_q      <= option_d;
            out_enable_q  <= out_enable_d;
            pulse_q       <= pulse_d;
            write_pulse_q <= write_pulse_d;
            done_q        <= done_d;
            err_q         <= err_d;
        end
    end

    pulse_shadow #(
        .PULSE_CONTROL_BITS (PULSE_CONTROL_BITS)
    ) u_pulse_shadow (
        .clk         (clk),
        .rst_n       (rst_n),
        .out_enable  (out_enable_q),
        .write_pulse (write_pulse_q),
        .pulse       (pulse_q),
        .count       (shadow_count)
    );

    assign cmd.cmd_ready = (state_q == IDLE);
    assign busy          = (state_q == WAIT);
    assign divider       = divider_q;
    assign option        = option_q;
    assign out_enable    = out_enable_q;
    assign pulse         = pulse_q;
    assign write_pulse   = write_pulse_q;
    assign pulses_left   = shadow_count;
    assign done          = done_q;
    assign err           = err_q;

endmodule

// File: tb/tb_clk_ctrl_sequencer.sv
// Directed vector table followed by randomized commands checked against a behavioural model.
module tb_clk_ctrl_sequencer;

    typedef struct packed {
        logic        rdy;
        logic [31:0] div;
        logic        opt;
        logic        oe;
        logic [31:0] pulse;
        logic        wp;
        logic [31:0] left;
        logic        busy;
        logic        done;
        logic        err;
    } outs_t;

    typedef struct {
        logic        r;
        logic        v;
        logic [31:0] d;
        outs_t       exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    clk_ctrl_sequencer_if cmd_bus();

    logic [31:0] divider, pulse, pulses_left;
    logic        option, out_enable, write_pulse, busy, done, err;

    clk_ctrl_sequencer #(
        .COUNTER_BITS       (32),
        .PULSE_CONTROL_BITS (32),
        .DEFAULT_DIVIDER    (2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cmd         (cmd_bus),
        .divider     (divider),
        .option      (option),
        .out_enable  (out_enable),
        .pulse       (pulse),
        .write_pulse (write_pulse),
        .pulses_left (pulses_left),
        .busy        (busy),
        .done        (done),
        .err         (err)
    );

    int vec_cnt = 0;
    int miss_cnt = 0;
    vec_t vec_q[$];

    // Behavioural model state: the values every output should show after the last edge.
    logic        m_waiting, m_opt, m_oe, m_wp, m_done, m_err;
    logic [31:0] m_div, m_pulse, m_left;

    function automatic string fmt(input outs_t o);
        return $sformatf("rdy=%0b div=%0h opt=%0b oe=%0b pulse=%0h wp=%0b left=%0h busy=%0b done=%0b err=%0b",
                         o.rdy, o.div, o.opt, o.oe, o.pulse, o.wp, o.left, o.busy, o.done, o.err);
    endfunction

    function automatic outs_t actual();
        outs_t o;
        o = '{rdy: cmd_bus.cmd_ready, div: divider, opt: option, oe: out_enable, pulse: pulse,
              wp: write_pulse, left: pulses_left, busy: busy, done: done, err: err};
        return o;
    endfunction

    function automatic outs_t model_outs();
        outs_t o;
        o = '{rdy: !m_waiting, div: m_div, opt: m_opt, oe: m_oe, pulse: m_pulse,
              wp: m_wp, left: m_left, busy: m_waiting, done: m_done, err: m_err};
        return o;
    endfunction

    task automatic check(input string name, input int idx, input outs_t exp);
        outs_t act;
        act = actual();
        vec_cnt++;
        if (act !== exp) begin
            miss_cnt++;
            $display("FAIL %s[%0d] got %s required %s", name, idx, fmt(act), fmt(exp));
        end
    endtask

    // Advance the model by one clock edge using the rules for command decode,
    // the downstream pulse counter, and the wait/done handshake.
    task automatic model_step(input logic r, input logic v, input logic [31:0] d);
        logic [31:0] arg, n_left, n_div, n_pulse;
        logic        n_waiting, n_opt, n_oe, n_wp, n_done, n_err;
        if (!r) begin
            m_waiting = 0; m_opt = 0; m_oe = 0; m_wp = 0; m_done = 0; m_err = 0;
            m_div = 2; m_pulse = 0; m_left = 0;
            return;
        end
        n_left = m_left;
        if (m_oe && n_left > 0) n_left = n_left - 1;
        if (m_wp) n_left = m_pulse;
        n_div = m_div; n_pulse = m_pulse; n_waiting = m_waiting; n_opt = m_opt;
        n_oe = m_oe; n_wp = 0; n_done = 0; n_err = m_err;
        arg = {8'h00, d[23:0]};
        if (m_waiting) begin
            if (!m_wp && m_left == 0) begin
                n_waiting = 0;
                n_done = 1;
            end
        end else if (v) begin
            case (d[31:24])
                8'h01: n_div = (arg < 2) ? 32'd2 : arg;
                8'h02: n_opt = arg[0];
                8'h03: n_oe = arg[0];
                8'h04: begin n_pulse = arg; n_wp = 1; end
                8'h05: begin
                    n_pulse = arg; n_wp = 1;
                    if (!m_oe) n_err = 1;
                    else if (arg == 0) n_done = 1;
                    else n_waiting = 1;
                end
                8'h06: begin n_oe = 0; n_pulse = 0; n_wp = 1; end
                8'h07: n_err = 0;
                default: n_err = 1;
            endcase
        end
        m_left = n_left; m_div = n_div; m_pulse = n_pulse; m_waiting = n_waiting;
        m_opt = n_opt; m_oe = n_oe; m_wp = n_wp; m_done = n_done; m_err = n_err;
    endtask

    task automatic step(input logic r, input logic v, input logic [31:0] d);
        @(negedge clk);
        rst_n = r;
        cmd_bus.cmd_valid = v;
        cmd_bus.cmd_data = d;
        if (r && v && !m_waiting) $display("txn t=%0t cmd=%08h", $time, d);
        model_step(r, v, d);
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic r, input logic v, input logic [31:0] d,
                       input logic rdy, input logic [31:0] div, input logic opt, input logic oe,
                       input logic [31:0] pl, input logic wp, input logic [31:0] left,
                       input logic bsy, input logic dn, input logic er);
        vec_t t;
        t.r = r; t.v = v; t.d = d;
        t.exp = '{rdy: rdy, div: div, opt: opt, oe: oe, pulse: pl, wp: wp,
                  left: left, busy: bsy, done: dn, err: er};
        vec_q.push_back(t);
    endtask

    initial begin
        logic [31:0] d;
        logic        r, v;
        int          pick;

        cmd_bus.cmd_valid = 0;
        cmd_bus.cmd_data = '0;
        model_step(1'b0, 1'b0, 32'h0);

        //  r  v  data          rdy div        opt oe pulse wp left busy done err
        add(0, 0, 32'h00000000, 1, 2,         0, 0, 0,   0, 0,   0, 0, 0);
        add(0, 1, 32'h0100000A, 1, 2,         0, 0, 0,   0, 0,   0, 0, 0);
        add(1, 0, 32'h00000000, 1, 2,         0, 0, 0,   0, 0,   0, 0, 0);
        add(1, 1, 32'h0100000A, 1, 10,        0, 0, 0,   0, 0,   0, 0, 0);
        add(1, 1, 32'h01000001, 1, 2,         0, 0, 0,   0, 0,   0, 0, 0);
        add(1, 1, 32'h01FFFFFF, 1, 32'hFFFFFF, 0, 0, 0,  0, 0,   0, 0, 0);
        add(1, 1, 32'h02000001, 1, 32'hFFFFFF, 1, 0, 0,  0, 0,   0, 0, 0);
        add(1, 1, 32'h02000002, 1, 32'hFFFFFF, 0, 0, 0,  0, 0,   0, 0, 0);
        add(1, 1, 32'h03000001, 1, 32'hFFFFFF, 0, 1, 0,  0, 0,   0, 0, 0);
        add(1, 1, 32'h05000003, 0, 32'hFFFFFF, 0, 1, 3,  1, 0,   1, 0, 0);
        add(1, 1, 32'h01000005, 0, 32'hFFFFFF, 0, 1, 3,  0, 3,   1, 0, 0);
        add(1, 1, 32'h01000005, 0, 32'hFFFFFF, 0, 1, 3,  0, 2,   1, 0, 0);
        add(1, 1, 32'h01000005, 0, 32'hFFFFFF, 0, 1, 3,  0, 1,   1, 0, 0);
        add(1, 1, 32'h01000005, 0, 32'hFFFFFF, 0, 1, 3,  0, 0,   1, 0, 0);
        add(1, 1, 32'h01000005, 1, 32'hFFFFFF, 0, 1, 3,  0, 0,   0, 1, 0);
        add(1, 1, 32'h01000005, 1, 5,         0, 1, 3,   0, 0,   0, 0, 0);
        add(1, 0, 32'h00000000, 1, 5,         0, 1, 3,   0, 0,   0, 0, 0);
        add(1, 1, 32'h03000000, 1, 5,         0, 0, 3,   0, 0,   0, 0, 0);
        add(1, 1, 32'h05000005, 1, 5,         0, 0, 5,   1, 0,   0, 0, 1);
        add(1, 0, 32'h00000000, 1, 5,         0, 0, 5,   0, 5,   0, 0, 1);
        add(1, 0, 32'h00000000, 1, 5,         0, 0, 5,   0, 5,   0, 0, 1);
        add(1, 1, 32'h07000000, 1, 5,         0, 0, 5,   0, 5,   0, 0, 0);
        add(1, 1, 32'hFF123456, 1, 5,         0, 0, 5,   0, 5,   0, 0, 1);
        add(1, 1, 32'h00000000, 1, 5,         0, 0, 5,   0, 5,   0, 0, 1);
        add(1, 1, 32'h03000001, 1, 5,         0, 1, 5,   0, 5,   0, 0, 1);
        add(1, 1, 32'h05000000, 1, 5,         0, 1, 0,   1, 4,   0, 1, 1);
        add(1, 0, 32'h00000000, 1, 5,         0, 1, 0,   0, 0,   0, 0, 1);
        add(1, 1, 32'h04000007, 1, 5,         0, 1, 7,   1, 0,   0, 0, 1);
        add(1, 0, 32'h00000000, 1, 5,         0, 1, 7,   0, 7,   0, 0, 1);
        add(1, 1, 32'h06000000, 1, 5,         0, 0, 0,   1, 6,   0, 0, 1);
        add(1, 0, 32'h00000000, 1, 5,         0, 0, 0,   0, 0,   0, 0, 1);
        add(1, 1, 32'h07000000, 1, 5,         0, 0, 0,   0, 0,   0, 0, 0);
        add(1, 1, 32'h03000001, 1, 5,         0, 1, 0,   0, 0,   0, 0, 0);
        add(1, 1, 32'h02000001, 1, 5,         1, 1, 0,   0, 0,   0, 0, 0);
        add(1, 1, 32'h05000064, 0, 5,         1, 1, 100, 1, 0,   1, 0, 0);
        add(1, 0, 32'h00000000, 0, 5,         1, 1, 100, 0, 100, 1, 0, 0);
        add(1, 0, 32'h00000000, 0, 5,         1, 1, 100, 0, 99,  1, 0, 0);
        add(0, 0, 32'h00000000, 1, 2,         0, 0, 0,   0, 0,   0, 0, 0);
        add(1, 0, 32'h00000000, 1, 2,         0, 0, 0,   0, 0,   0, 0, 0);
        add(1, 0, 32'h00000000, 1, 2,         0, 0, 0,   0, 0,   0, 0, 0);

        foreach (vec_q[i]) begin
            step(vec_q[i].r, vec_q[i].v, vec_q[i].d);
            check("table", i, vec_q[i].exp);
        end

        // Randomized command stream; args kept small so waits drain quickly.
        for (int i = 0; i < 800; i++) begin
            r = ($urandom_range(0, 99) != 0);
            v = ($urandom_range(0, 9) < 7);
            pick = $urandom_range(0, 9);
            case (pick)
                0: d = {8'h01, 24'($urandom_range(0, 3) == 0 ? $urandom_range(0, 2) : $urandom)};
                1: d = {8'h02, 24'($urandom)};
                2, 3: d = {8'h03, 23'($urandom), 1'($urandom_range(0, 3) != 0)};
                4: d = {8'h04, 24'($urandom_range(0, 15))};
                5, 6: d = {8'h05, 24'($urandom_range(0, 12))};
                7: d = {8'h06, 24'($urandom)};
                8: d = {8'h07, 24'($urandom)};
                default: d = $urandom;
            endcase
            step(r, v, d);
            check("random", i, model_outs());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
